audio_frame_sequencer: RTL and testbench
========================================

Name: audio_frame_sequencer

Overview:
Sample-rate scheduler that sits between the voice generators and the delta-sigma DAC. On every sample tick it polls each voice in turn over a req/ack handshake and sums the returned samples. It then applies master volume with saturation and presents one signed 14-bit sample to the DAC as a single-cycle valid pulse. It also flags late voices (timeout) and sample ticks that arrive while a frame is still in progress (overrun).

Parameters:
NUM_VOICES, 3, number of voice requesters, 1..8
SAMPLE_DIV, 1000, clk_i cycles per sample tick (50 MHz / 1000 = 50 kHz), >= NUM_VOICES+3
WAIT_MAX, 15, max cycles a request stays high without ack before it is abandoned

Ports:
clk_i  in  1  system clock, 50 MHz
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  enables tick generation
voice_req_o  out  NUM_VOICES  one-hot request to the polled voice
voice_ack_i  in  1  voice_data_i valid for the requested voice
voice_data_i  in  12 signed  voice sample
voice_mute_i  in  NUM_VOICES  per-voice mute; muted voices are skipped
volume_i  in  5  master volume, unsigned, 16 = unity, values >16 clamp to 16
clear_i  in  1  clears the sticky flags
audio_valid_o  out  1  one-cycle strobe, audio_o updated
audio_o  out  14 signed  mixed sample, held between strobes
busy_o  out  1  high while the FSM is not in IDLE
timeout_o  out  1  sticky: at least one voice was abandoned
overrun_o  out  1  sticky: a tick was dropped

Behaviour:
- Reset values: all outputs 0. Counter, accumulator and voice index are 0. FSM is in IDLE.
- Reset asserted mid-frame aborts the frame immediately. No valid pulse is produced.
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 while enable_i=1.
  - Generates a tick in the cycle where count==SAMPLE_DIV-1, then wraps to 0.
  - When enable_i=0 the counter is forced to 0 and no ticks are generated. A frame already in progress still completes.
- FSM states: IDLE, REQ, SCALE, OUT.
- IDLE:
  - On a tick: clear the accumulator, set index to 0, go to REQ.
  - No tick: stay in IDLE.
- REQ, voice at index i:
  - If voice_mute_i[i]=1: add nothing and advance in 1 cycle. voice_req_o stays 0 for that cycle.
  - Otherwise: voice_req_o[i]=1, driven from the FSM state and index (no extra delay).
  - Ack with req high: in the same cycle, add sign-extended voice_data_i to the accumulator, drop req and advance. Ack in the first cycle therefore costs 1 cycle per voice.
  - No ack after WAIT_MAX cycles with req high: add 0, set timeout_o, advance.
  - voice_ack_i is ignored whenever no request is asserted.
  - After the last index, go to SCALE.
- Accumulator width: 12+ceil(log2(NUM_VOICES+1)) bits, signed. It never overflows.
- SCALE (1 cycle):
  - Compute product = acc * vol, where vol = min(volume_i, 16) and volume_i is sampled in this cycle.
  - Arithmetic right shift by 4 (floor toward minus infinity).
  - Saturate to [-8192, 8191] and register the result into audio_o.
- OUT (1 cycle): audio_valid_o=1, then return to IDLE.
- Latency: with all voices acking in the first cycle (or muted), audio_valid_o is high exactly NUM_VOICES+2 cycles after the tick cycle.
- Overrun: a tick that occurs while the FSM is not in IDLE is dropped and sets overrun_o. The current frame is unaffected.
- Sticky flags:
  - clear_i=1 clears timeout_o and overrun_o.
  - If a set event and clear_i occur in the same cycle, set wins.
- At most one bit of voice_req_o is ever high.

Test Plan:
- NUM_VOICES=3, SAMPLE_DIV=8, immediate acks with data 1000, -500, 200, volume 16 -> audio_o=700, audio_valid_o 5 cycles after each tick, one pulse every 8 cycles.
- Same data, volume 8 -> 350. Data 1000, -1701, 0 with volume 8 -> -351 (floor). volume 31 -> 700 (clamped to 16).
- NUM_VOICES=5, all data 2047, volume 16 -> audio_o=8191. All data -2048 -> -8192.
- voice_mute_i=3'b010 with data 1000, -500, 200 -> voice_req_o[1] never asserted, audio_o=1200, valid 5 cycles after the tick.
- Voice 2 never acks, WAIT_MAX=15, SAMPLE_DIV=32 -> req held 15 cycles then dropped, timeout_o=1, audio_o=500. clear_i pulse -> timeout_o=0.
- SAMPLE_DIV=8, WAIT_MAX=15, voice 0 silent -> overrun_o=1 with the next tick dropped. Also check rst_ni low mid-REQ -> all outputs 0 next cycle and no valid pulse.

Source files
------------

// File: rtl/audio_frame_sequencer.sv
// Sample-rate frame sequencer: polls each voice over req/ack on every sample tick,
// sums the samples, applies saturating master volume and strobes one 14-bit sample out.
module audio_frame_sequencer #(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_DIV = 1000,
    parameter int WAIT_MAX   = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    output logic [NUM_VOICES-1:0]   voice_req_o,
    input  logic                    voice_ack_i,
    input  logic signed [11:0]      voice_data_i,
    input  logic [NUM_VOICES-1:0]   voice_mute_i,
    input  logic [4:0]              volume_i,
    input  logic                    clear_i,
    output logic                    audio_valid_o,
    output logic signed [13:0]      audio_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic                    overrun_o
);

    localparam int ACC_W  = 12 + $clog2(NUM_VOICES + 1);
    localparam int PROD_W = ACC_W + 6;
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W  = $clog2(SAMPLE_DIV);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(8191);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-8192);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [13:0]        audio_q, audio_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      timeout_q, timeout_d;
    logic                      overrun_q, overrun_d;

    logic                      tick_s;
    logic                      req_active_s;
    logic                      advance_s;
    logic                      timeout_set_s;
    logic                      overrun_set_s;

    // Volume is clamped to unity (16), applied as acc*vol/16 with floor, then saturated.
    function automatic logic signed [13:0] scale_sat(input logic signed [ACC_W-1:0] acc,
                                                     input logic [4:0] vol_raw);
        logic [4:0]               vol;
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shf;
        vol  = (vol_raw > 5'd16) ? 5'd16 : vol_raw;
        prod = PROD_W'(acc) * PROD_W'($signed({1'b0, vol}));
        shf  = prod >>> 4;
        if (shf > SAT_MAX) begin
            scale_sat = 14'sh1fff;
        end else if (shf < SAT_MIN) begin
            scale_sat = 14'sh2000;
        end else begin
            scale_sat = shf[13:0];
        end
    endfunction

    assign tick_s       = enable_i && (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign req_active_s = (state_q == ST_REQ) && !voice_mute_i[idx_q];
    assign voice_req_o  = req_active_s ? (NUM_VOICES'(1) << idx_q) : '0;

    // Tick divider, held at zero while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i) begin
            cnt_d = '0;
        end else if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Frame FSM: next state, voice polling, accumulation and scaling.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        acc_d         = acc_q;
        audio_d       = audio_q;
        advance_s     = 1'b0;
        timeout_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    wait_d  = '0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!req_active_s) begin
                    advance_s = 1'b1;
                end else if (voice_ack_i) begin
                    acc_d     = acc_q + ACC_W'(voice_data_i);
                    advance_s = 1'b1;
                end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
                    advance_s     = 1'b1;
                    timeout_set_s = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (advance_s) begin
                    wait_d = '0;
                    if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                        state_d = ST_SCALE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SCALE: begin
                audio_d = scale_sat(acc_q, volume_i);
                state_d = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags (a set event beats a simultaneous clear) and registered status.
    always_comb begin
        overrun_set_s = tick_s && (state_q != ST_IDLE);
        if (timeout_set_s) begin
            timeout_d = 1'b1;
        end else if (clear_i) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
        if (overrun_set_s) begin
            overrun_d = 1'b1;
        end else if (clear_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        valid_d = (state_d == ST_OUT);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
            acc_q     <= '0;
            audio_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            acc_q     <= acc_d;
            audio_q   <= audio_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign audio_o       = audio_q;
    assign audio_valid_o = valid_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed plus randomized frames against a frame-level reference model of the sequencer.
module tb_audio_frame_sequencer;

    localparam int N   = 5;
    localparam int DIV = 32;
    localparam int WM  = 15;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                ack = 1'b0;
    logic                clear = 1'b0;
    logic signed [11:0]  vdata = 12'sd0;
    logic [N-1:0]        mute = '0;
    logic [4:0]          volume = 5'd16;
    logic [N-1:0]        req;
    logic                valid, busy, tmo, ovr;
    logic signed [13:0]  audio;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dly[N];
    int dat[N];
    logic [N-1:0] prev_req = '0;
    int hold = 0;

    audio_frame_sequencer #(.NUM_VOICES(N), .SAMPLE_DIV(DIV), .WAIT_MAX(WM)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .voice_req_o(req), .voice_ack_i(ack), .voice_data_i(vdata),
        .voice_mute_i(mute), .volume_i(volume), .clear_i(clear),
        .audio_valid_o(valid), .audio_o(audio), .busy_o(busy),
        .timeout_o(tmo), .overrun_o(ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Voice model: voice i acks after dly[i] cycles of its own request; noise otherwise.
    always @(negedge clk) begin
        int idx;
        if (req != '0 && req == prev_req) hold = hold + 1;
        else hold = 0;
        prev_req = req;
        if (req != '0) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (req[i]) idx = i;
            ack   = (hold == dly[idx]);
            vdata = ack ? 12'(dat[idx]) : 12'($urandom);
        end else begin
            ack   = 1'($urandom_range(0, 1));
            vdata = 12'($urandom);
        end
        if (rst_n) begin
            chk("req_onehot", longint'($countones(req) <= 1), 1);
            chk("req_muted", longint'(req & mute), 0);
        end
    end

    function automatic int m_cycles();
        int s = 2;
        for (int i = 0; i < N; i++) begin
            if (mute[i]) s += 1;
            else if (dly[i] < WM) s += dly[i] + 1;
            else s += WM;
        end
        return s;
    endfunction

    function automatic int m_sum();
        int s = 0;
        for (int i = 0; i < N; i++) if (!mute[i] && dly[i] < WM) s += dat[i];
        return s;
    endfunction

    function automatic bit m_tmo();
        bit t = 1'b0;
        for (int i = 0; i < N; i++) if (!mute[i] && dly[i] >= WM) t = 1'b1;
        return t;
    endfunction

    function automatic int m_audio(input int sum, input int vol_raw);
        int v, p, q;
        v = (vol_raw > 16) ? 16 : vol_raw;
        p = sum * v;
        q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        if (q > 8191) q = 8191;
        if (q < -8192) q = -8192;
        return q;
    endfunction

    task automatic set_cfg(input int d0, input int d1, input int d2, input int d3, input int d4,
                           input logic [N-1:0] m, input int vol);
        dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3; dat[4] = d4;
        for (int i = 0; i < N; i++) dly[i] = 0;
        mute   = m;
        volume = 5'(vol);
    endtask

    task automatic run_test(input string name, input int nframes);
        int c, tick, vt, got, fc, exp_a, nxt;
        bit etmo, eovr;
        etmo = 1'b0;
        eovr = 1'b0;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk({name, ":clr_tmo"}, longint'(tmo), 0);
        chk({name, ":clr_ovr"}, longint'(ovr), 0);
        c = cyc;
        enable = 1'b1;
        tick  = c + DIV - 1;
        fc    = m_cycles();
        exp_a = m_audio(m_sum(), int'(volume));
        for (int f = 0; f < nframes; f++) begin
            vt = tick + fc;
            while (cyc < tick + 1) @(negedge clk);
            if (f == nframes - 1) enable = 1'b0;
            got = -1;
            while (got < 0 && cyc <= vt + 3) begin
                if (valid) got = cyc;
                else @(negedge clk);
            end
            chk({name, ":latency"}, got - tick, vt - tick);
            chk({name, ":audio"}, longint'(audio), exp_a);
            if (m_tmo()) etmo = 1'b1;
            nxt = tick + DIV;
            if (f != nframes - 1) begin
                while (nxt <= vt) begin
                    eovr = 1'b1;
                    nxt += DIV;
                end
            end
            @(negedge clk);
            chk({name, ":pulse1"}, longint'(valid), 0);
            chk({name, ":timeout"}, longint'(tmo), longint'(etmo));
            chk({name, ":overrun"}, longint'(ovr), longint'(eovr));
            tick = nxt;
        end
    endtask

    initial begin
        int c, pulses;
        for (int i = 0; i < N; i++) begin
            dly[i] = 0;
            dat[i] = 0;
        end
        @(negedge clk);
        chk("rst:valid", longint'(valid), 0);
        chk("rst:audio", longint'(audio), 0);
        chk("rst:busy", longint'(busy), 0);
        chk("rst:req", longint'(req), 0);
        chk("rst:flags", longint'({tmo, ovr}), 0);
        rst_n = 1'b1;

        set_cfg(1000, -500, 200, 0, 0, 5'b11000, 16);  run_test("unity", 3);
        set_cfg(1000, -500, 200, 0, 0, 5'b11000, 8);   run_test("vol8", 2);
        set_cfg(1000, -1701, 0, 0, 0, 5'b11000, 8);    run_test("floor", 1);
        set_cfg(1000, -500, 200, 0, 0, 5'b11000, 31);  run_test("vclamp", 1);
        set_cfg(2047, 2047, 2047, 2047, 2047, 5'b00000, 16);       run_test("sat_pos", 1);
        set_cfg(-2048, -2048, -2048, -2048, -2048, 5'b00000, 16);  run_test("sat_neg", 1);
        set_cfg(1000, -500, 200, 0, 0, 5'b11010, 16);  run_test("mute1", 2);
        set_cfg(1000, -500, 200, 0, 0, 5'b11000, 16);  dly[2] = WM; run_test("timeout", 1);
        set_cfg(1000, -500, 200, 0, 0, 5'b11000, 16);  dly[0] = WM; dly[1] = WM;
        run_test("overrun", 2);

        for (int r = 0; r < 10; r++) begin
            set_cfg($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048,
                    $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048,
                    $urandom_range(0, 4095) - 2048, 5'($urandom), $urandom_range(0, 31));
            for (int i = 0; i < N; i++)
                dly[i] = ($urandom_range(0, 7) == 0) ? WM : $urandom_range(0, 3);
            run_test("rand", 2);
        end

        // Reset in the middle of a voice request aborts the frame.
        set_cfg(1000, -500, 200, 0, 0, 5'b00000, 16);
        dly[0] = WM;
        repeat (4) @(negedge clk);
        c = cyc;
        enable = 1'b1;
        while (cyc < c + DIV + 2) @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("midrst:req", longint'(req), 0);
        chk("midrst:valid", longint'(valid), 0);
        chk("midrst:audio", longint'(audio), 0);
        chk("midrst:busy", longint'(busy), 0);
        chk("midrst:flags", longint'({tmo, ovr}), 0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (90) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        chk("midrst:no_pulse", pulses, 0);
        chk("midrst:idle", longint'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
